// File: rtl/indirect_csr_arbiter_if.sv
// Requester and indirect CSR bus bundle for indirect_csr_arbiter.
// master = arbiter side, slave = requesters plus the CSR bridge.
interface indirect_csr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 16,
  parameter int AW      = 19,
  parameter int DW      = 64
);
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    i_req_write;
  logic [NUM_REQ*AW-1:0] i_req_addr;
  logic [NUM_REQ*DW-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ-1:0]    o_rsp_valid;
  logic [DW-1:0]         o_rsp_rdata;
  logic [1:0]            o_rsp_resp;
  logic                  o_rsp_timeout;
  logic [CMD_W-1:0]      o_csr_cmd;
  logic [AW-1:0]         o_csr_addr;
  logic [DW-1:0]         o_csr_writedata;
  logic [DW-1:0]         i_csr_readdata;
  logic                  i_csr_ack;
  logic [1:0]            i_csr_rresp;
  logic [1:0]            i_csr_bresp;
  logic                  o_busy;

  modport master (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
    input  i_csr_readdata, i_csr_ack, i_csr_rresp, i_csr_bresp,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_timeout,
    output o_csr_cmd, o_csr_addr, o_csr_writedata, o_busy
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
    output i_csr_readdata, i_csr_ack, i_csr_rresp, i_csr_bresp,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_timeout,
    input  o_csr_cmd, o_csr_addr, o_csr_writedata, o_busy
  );
endinterface

// File: rtl/indirect_csr_arbiter.sv
// Round-robin arbiter sharing one indirect CSR port among NUM_REQ requesters,
// one single-beat transaction at a time, with a forced SLVERR on missing ack.
module indirect_csr_arbiter #(
  parameter int               NUM_REQ     = 4,
  parameter int               CMD_W       = 16,
  parameter int               AW          = 19,
  parameter int               DW          = 64,
  parameter logic [CMD_W-1:0] RD_CMD      = 16'h0001,
  parameter logic [CMD_W-1:0] WR_CMD      = 16'h0002,
  parameter int               TIMEOUT_CYC = 1024
) (
  input logic                    i_csr_clk,
  input logic                    i_csr_rst_n,
  indirect_csr_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [IW-1:0] owner;
  } txn_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          timeout;
  } rsp_t;

  state_t        state, state_nxt;
  txn_t          txn;
  rsp_t          rsp;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic          win_vld;
  logic [CW-1:0] cnt;
  logic          ack_hit;
  logic          tmo_hit;
  int            idx;

  logic [AW-1:0] req_addr  [NUM_REQ];
  logic [DW-1:0] req_wdata [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_addr[k]  = bus.i_req_addr[k*AW +: AW];
    assign req_wdata[k] = bus.i_req_wdata[k*DW +: DW];
  end

  // Search starts at rr_ptr (one past the last winner) and wraps.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && bus.i_req_valid[IW'(idx)]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  // Ack takes priority when it lands in the timeout cycle.
  assign ack_hit = (state == CMD) && bus.i_csr_ack;
  assign tmo_hit = (state == CMD) && !bus.i_csr_ack && (cnt == CW'(TIMEOUT_CYC-1));

  always_ff @(posedge i_csr_clk or negedge i_csr_rst_n) begin
    if (!i_csr_rst_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = CMD;
      CMD:     if (ack_hit || tmo_hit) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_ready = '0;
    bus.o_rsp_valid = '0;
    bus.o_csr_cmd   = '0;
    case (state)
      IDLE:    if (win_vld && i_csr_rst_n) bus.o_req_ready[win] = 1'b1;
      CMD:     bus.o_csr_cmd = txn.write ? WR_CMD : RD_CMD;
      RSP:     bus.o_rsp_valid[txn.owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_csr_clk or negedge i_csr_rst_n) begin
    if (!i_csr_rst_n) begin
      txn    <= '0;
      rsp    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          txn.write <= bus.i_req_write[win];
          txn.addr  <= req_addr[win];
          txn.wdata <= req_wdata[win];
          txn.owner <= win;
          rr_ptr    <= (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
        CMD: begin
          cnt <= cnt + 1'b1;
          if (ack_hit) begin
            rsp.rdata   <= txn.write ? '0 : bus.i_csr_readdata;
            rsp.resp    <= txn.write ? bus.i_csr_bresp : bus.i_csr_rresp;
            rsp.timeout <= 1'b0;
          end else if (tmo_hit) begin
            rsp.rdata   <= '1;
            rsp.resp    <= 2'b10;
            rsp.timeout <= 1'b1;
          end
        end
        RSP:     cnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.o_csr_addr      = txn.addr;
  assign bus.o_csr_writedata = txn.wdata;
  assign bus.o_rsp_rdata     = rsp.rdata;
  assign bus.o_rsp_resp      = rsp.resp;
  assign bus.o_rsp_timeout   = rsp.timeout;
  assign bus.o_busy          = (state != IDLE);
endmodule

// File: tb/tb_indirect_csr_arbiter.sv
// Scoreboard bench: requesters push expected responses per owner, a slave model
// answers the CSR port, monitors check grants, responses and timing.
module tb_indirect_csr_arbiter;
  localparam int               NUM_REQ     = 4;
  localparam int               CMD_W       = 16;
  localparam int               AW          = 19;
  localparam int               DW          = 64;
  localparam int               TIMEOUT_CYC = 16;
  localparam logic [CMD_W-1:0] RD_CMD      = 16'h0001;
  localparam logic [CMD_W-1:0] WR_CMD      = 16'h0002;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  indirect_csr_arbiter_if #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .AW(AW), .DW(DW)) bus ();

  indirect_csr_arbiter #(
    .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .AW(AW), .DW(DW),
    .RD_CMD(RD_CMD), .WR_CMD(WR_CMD), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_csr_clk   (clk),
    .i_csr_rst_n (rst_n),
    .bus         (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-requester slave behaviour for the transaction it currently has open.
  bit            plan_write  [NUM_REQ];
  bit            plan_active [NUM_REQ];
  logic [AW-1:0] plan_addr   [NUM_REQ];
  logic [DW-1:0] plan_wdata  [NUM_REQ];
  logic [DW-1:0] plan_rdata  [NUM_REQ];
  logic [1:0]    plan_resp   [NUM_REQ];
  int            plan_delay  [NUM_REQ];

  exp_t exp_q [NUM_REQ][$];
  int   cyc_q[$];
  int   grant_log[$];
  int   rr_last = -1;
  int   grant_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      exp_q[k].delete();
      plan_active[k] = 1'b0;
    end
    cyc_q.delete();
    grant_log.delete();
    rr_last = -1;
  endtask

  // Caller is positioned just after a rising edge.
  task automatic issue(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int d, input logic [DW-1:0] rd, input logic [1:0] rs);
    exp_t x;
    int   n;
    plan_write[k] = wr;  plan_addr[k] = a;  plan_wdata[k] = wd;
    plan_rdata[k] = rd;  plan_resp[k] = rs; plan_delay[k] = d;
    plan_active[k] = 1'b1;
    if (d >= 0 && d < TIMEOUT_CYC) begin
      x.rdata = wr ? '0 : rd;
      x.resp  = rs;
      x.tmo   = 1'b0;
    end else begin
      x.rdata = '1;
      x.resp  = 2'b10;
      x.tmo   = 1'b1;
    end
    exp_q[k].push_back(x);
    bus.i_req_write[k]          = wr;
    bus.i_req_addr[k*AW +: AW]  = a;
    bus.i_req_wdata[k*DW +: DW] = wd;
    bus.i_req_valid[k]          = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_req_ready[k]) break;
      n++;
      if (n > 400) begin
        checks++; failures++;
        $display("FAIL accept_wait: requester %0d never accepted", k);
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        checks++; failures++;
        $display("FAIL rsp_wait: requester %0d response missing", k);
        exp_q[k].delete();
        break;
      end
    end
  endtask

  task automatic stream(input int k, input int n);
    logic [15:0] hi;
    int          r, d;
    bit          wr;
    for (int j = 0; j < n; j++) begin
      hi = 16'($urandom);
      wr = 1'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 6)       d = $urandom_range(0, 4);
      else if (r == 6) d = TIMEOUT_CYC - 1;
      else if (r == 7) d = -1;
      else             d = $urandom_range(5, TIMEOUT_CYC - 2);
      issue(k, wr, {hi, 3'(k)}, {$urandom, $urandom}, d, {$urandom, $urandom}, 2'($urandom));
      wait_rsp(k);
      @(posedge clk); #1;
    end
  endtask

  task automatic fixed_stream(input int k);
    for (int j = 0; j < 2; j++) begin
      issue(k, 1'b0, {16'(j + 1), 3'(k)}, 64'(k), 1, {32'(k), 32'(j)}, 2'b00);
      wait_rsp(k);
      @(posedge clk); #1;
    end
  endtask

  // Grant monitor: first valid requester after the previous winner.
  int g_e, g_a, g_idx;
  always @(negedge clk) begin
    if (rst_n && bus.o_req_ready != '0) begin
      g_e = -1;
      g_a = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        g_idx = (rr_last + 1 + i) % NUM_REQ;
        if (g_e < 0 && bus.i_req_valid[g_idx]) g_e = g_idx;
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.o_req_ready[i]) g_a = (g_a < 0) ? i : 99;
      chk("grant", 64'(g_a), 64'(g_e));
      rr_last = g_e;
      grant_cyc = cyc;
      grant_log.push_back(g_a);
    end
  end

  // Response monitor: pops the owner's queue and the global timing queue.
  int   r_k;
  exp_t r_x;
  always @(negedge clk) begin
    if (rst_n && bus.o_rsp_valid != '0) begin
      chk("rsp_onehot", 64'($countones(bus.o_rsp_valid)), 64'd1);
      r_k = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.o_rsp_valid[i]) r_k = i;
      if (exp_q[r_k].size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_unexpected: requester %0d got a response, none pending", r_k);
      end else begin
        r_x = exp_q[r_k].pop_front();
        chk("rsp_rdata", bus.o_rsp_rdata, r_x.rdata);
        chk("rsp_resp", 64'(bus.o_rsp_resp), 64'(r_x.resp));
        chk("rsp_timeout", 64'(bus.o_rsp_timeout), 64'(r_x.tmo));
        plan_active[r_k] = 1'b0;
      end
      if (cyc_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp_cycle: response at cycle %0d with no command seen", cyc);
      end else begin
        chk("rsp_cycle", 64'(cyc), 64'(cyc_q.pop_front()));
      end
    end
  end

  // CSR slave model.
  int s_k, s_d, s_last, s_exit, s_gap;
  bit s_seen;
  initial begin : slave
    bus.i_csr_ack = 1'b0;
    bus.i_csr_readdata = '0;
    bus.i_csr_rresp = 2'b00;
    bus.i_csr_bresp = 2'b00;
    s_gap = 0;
    s_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_seen = 1'b0;
        s_gap = 0;
      end else if (bus.o_csr_cmd == '0) begin
        s_gap++;
      end else begin
        if (s_seen) chk("cmd_gap_ge2", 64'(s_gap >= 2), 64'd1);
        chk("cmd_latency", 64'(cyc), 64'(grant_cyc + 1));
        s_k = -1;
        for (int i = 0; i < NUM_REQ; i++)
          if (plan_active[i] && plan_addr[i] == bus.o_csr_addr) s_k = i;
        if (s_k < 0) begin
          checks++; failures++;
          $display("FAIL slave_owner: no open request for addr %h", bus.o_csr_addr);
        end else begin
          s_d    = plan_delay[s_k];
          s_exit = (s_d >= 0 && s_d < TIMEOUT_CYC) ? s_d : TIMEOUT_CYC - 1;
          s_last = (s_d >= 0) ? s_d : s_exit;
          cyc_q.push_back(cyc + s_exit + 1);
          for (int c = 0; c <= s_last; c++) begin
            if (!rst_n) break;
            if (c <= s_exit) begin
              chk("csr_cmd", 64'(bus.o_csr_cmd), 64'(plan_write[s_k] ? WR_CMD : RD_CMD));
              chk("csr_addr", 64'(bus.o_csr_addr), 64'(plan_addr[s_k]));
              chk("csr_wdata", bus.o_csr_writedata, plan_wdata[s_k]);
            end
            if (c == s_d) begin
              bus.i_csr_ack      = 1'b1;
              bus.i_csr_readdata = plan_rdata[s_k];
              bus.i_csr_rresp    = plan_write[s_k] ? ~plan_resp[s_k] : plan_resp[s_k];
              bus.i_csr_bresp    = plan_write[s_k] ? plan_resp[s_k] : ~plan_resp[s_k];
            end
            @(negedge clk);
            bus.i_csr_ack = 1'b0;
          end
          if (rst_n) chk("cmd_zero_after", 64'(bus.o_csr_cmd), 64'd0);
        end
        s_seen = 1'b1;
        s_gap = 1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int tot;
    bus.i_req_valid = '0;
    bus.i_req_write = '0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.i_req_valid = '1;
    #1;
    chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_cmd", 64'(bus.o_csr_cmd), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_addr", 64'(bus.o_csr_addr), 64'd0);
    chk("rst_wdata", bus.o_csr_writedata, 64'd0);
    chk("rst_rdata", bus.o_rsp_rdata, 64'd0);
    chk("rst_resp_tmo", 64'({bus.o_rsp_resp, bus.o_rsp_timeout}), 64'd0);
    bus.i_req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed read from requester 2, then write from requester 0.
    issue(2, 1'b0, 19'h00008, 64'h1111_2222_3333_4444, 3, 64'h0000_0000_1000_0020, 2'b00);
    wait_rsp(2);
    @(posedge clk); #1;
    issue(0, 1'b1, 19'h00010, 64'hDEAD_BEEF_0000_0001, 2, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00);
    wait_rsp(0);
    @(posedge clk); #1;

    // Fairness from a fresh pointer with all four contending.
    do_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fork
      fixed_stream(0);
      fixed_stream(1);
      fixed_stream(2);
      fixed_stream(3);
    join
    chk("rr_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("rr_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(i % NUM_REQ));

    // Timeout with a late ack, then a clean read must see its own data.
    issue(1, 1'b0, 19'h00021, 64'h0, TIMEOUT_CYC + 5, 64'hBAD0_BAD0_BAD0_BAD0, 2'b00);
    wait_rsp(1);
    repeat (10) @(posedge clk);
    #1;
    chk("late_ack_idle", 64'(bus.o_busy), 64'd0);
    issue(1, 1'b0, 19'h00031, 64'h0, 2, 64'h0123_4567_89AB_CDEF, 2'b01);
    wait_rsp(1);
    @(posedge clk); #1;

    // Ack exactly in the timeout cycle: read, then write.
    issue(3, 1'b0, 19'h00043, 64'h0, TIMEOUT_CYC - 1, 64'hCAFE_F00D_0000_0042, 2'b01);
    wait_rsp(3);
    @(posedge clk); #1;
    issue(3, 1'b1, 19'h00053, 64'h7777_0000_7777_0000, TIMEOUT_CYC - 1, 64'h1, 2'b11);
    wait_rsp(3);
    @(posedge clk); #1;

    // Randomised mix from all requesters.
    fork
      stream(0, 6);
      stream(1, 6);
      stream(2, 6);
      stream(3, 6);
    join

    // Reset in the middle of a command.
    issue(1, 1'b0, 19'h00061, 64'h55, -1, 64'h0, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    do_reset();
    #1;
    chk("midrst_cmd", 64'(bus.o_csr_cmd), 64'd0);
    chk("midrst_busy", 64'(bus.o_busy), 64'd0);
    chk("midrst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    @(posedge clk); #1;
    fork
      issue(3, 1'b0, 19'h00073, 64'h0, 2, 64'h3333_0000_0000_3333, 2'b00);
      issue(2, 1'b0, 19'h00072, 64'h0, 1, 64'h2222_0000_0000_2222, 2'b00);
      begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    wait_rsp(2);
    wait_rsp(3);
    chk("midrst_first_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'd2);
    repeat (5) @(posedge clk);
    #1;

    tot = 0;
    for (int k = 0; k < NUM_REQ; k++) tot += exp_q[k].size();
    chk("drain", 64'(tot), 64'd0);
    chk("end_idle", 64'(bus.o_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/indirect_csr_arbiter.md
Name: indirect_csr_arbiter

Overview:
- Round-robin arbiter that shares one indirect CSR master port (cmd/addr/writedata in, readdata/ack/rresp/bresp out) among NUM_REQ requesters.
- Serialises single-beat read/write transactions and holds the command stable until ack.
- Converts a missing ack into a timed-out SLVERR response.
- Sits between host-side CSR agents (mailbox, debug, management) and the indirect-to-AXI4-lite bridge.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_W, 16, indirect command width
AW, 19, CSR address width
DW, 64, data width
RD_CMD, 16'h0001, command value driven for a read
WR_CMD, 16'h0002, command value driven for a write
TIMEOUT_CYC, 1024, cycles to wait for ack before forced completion (>=2)

Ports:
i_csr_clk  in  1  clock
i_csr_rst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  NUM_REQ  per-requester request pending
i_req_write  in  NUM_REQ  1=write, 0=read
i_req_addr  in  NUM_REQ*AW  per-requester address, requester k at [k*AW +: AW]
i_req_wdata  in  NUM_REQ*DW  per-requester write data, requester k at [k*DW +: DW]
o_req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
o_rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester
o_rsp_rdata  out  DW  read data, valid with o_rsp_valid
o_rsp_resp  out  2  rresp for reads, bresp for writes, 2'b10 on timeout
o_rsp_timeout  out  1  high with o_rsp_valid when completion is forced by timeout
o_csr_cmd  out  CMD_W  indirect command
o_csr_addr  out  AW  indirect address
o_csr_writedata  out  DW  indirect write data
i_csr_readdata  in  DW  indirect read data
i_csr_ack  in  1  indirect acknowledgment, one-cycle pulse
i_csr_rresp  in  2  read response
i_csr_bresp  in  2  write response
o_busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- FSM: IDLE -> CMD -> RSP -> IDLE.
- IDLE:
  - Choose the first asserted i_req_valid starting at index (last_grant+1) mod NUM_REQ; after reset the search starts at index 0.
  - Pulse o_req_ready[win] in the same cycle.
  - Register addr, wdata, write flag and owner index; set last_grant=win; go to CMD.
  - No valid: stay in IDLE.
- CMD:
  - o_csr_cmd = WR_CMD or RD_CMD; o_csr_addr and o_csr_writedata hold the captured values, stable every cycle until exit.
  - Counter increments each cycle.
  - i_csr_ack=1: capture i_csr_readdata (reads only; writes capture 0) and rresp/bresp selected by the write flag; go to RSP.
  - Else, if counter reaches TIMEOUT_CYC-1: capture rdata all-ones and resp 2'b10; set timeout flag; go to RSP.
  - Ack and timeout in the same cycle: ack wins; timeout flag = 0.
- RSP:
  - o_csr_cmd = 0; o_rsp_valid[owner] = 1 for exactly one cycle with rdata, resp and timeout flag.
  - Counter clears; go to IDLE.
  - o_csr_cmd is therefore 0 for at least 2 cycles between transactions: RSP plus the IDLE grant cycle.
- Latency:
  - Accept at cycle t; cmd visible at t+1.
  - Ack at cycle a gives o_rsp_valid at a+1.
  - Minimum request-to-response time is 3 cycles.
- i_csr_ack outside CMD (late ack after a timeout) is ignored. It must not produce a response or corrupt the next transaction's captured data.
- Requesters keep i_req_valid and the payload stable until o_req_ready. Deasserting i_req_valid before accept withdraws the request.
- A requester may re-request in the cycle after its o_rsp_valid. Fairness then guarantees each other pending requester one grant first.
- o_rsp_rdata, o_rsp_resp and o_rsp_timeout hold their last values outside o_rsp_valid. They are undefined to the consumer in those cycles.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight transaction gets no response. o_csr_cmd drops to 0 asynchronously.

Test Plan:
- Single read, requester 2 at addr 19'h00008, slave acks 3 cycles after cmd with readdata 64'h0000_0000_1000_0020, rresp 0 -> o_req_ready[2] at t, o_csr_cmd=16'h0001 from t+1 until ack, o_rsp_valid[2] one cycle after ack with that data, resp 0.
- Write from requester 0, addr 19'h00010, data 64'hDEAD_BEEF_0000_0001, bresp 0 -> o_csr_cmd=16'h0002 and writedata stable until ack; response resp 0, rdata 0.
- All 4 requesters held valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; o_csr_cmd returns to 0 for >=2 cycles between commands.
- TIMEOUT_CYC=16, no ack -> o_rsp_valid after 16 cycles of cmd with rdata 64'hFFFF_FFFF_FFFF_FFFF, resp 2'b10, o_rsp_timeout=1. A late ack 5 cycles later is ignored, and the next read returns its own data.
- Ack arriving in the exact timeout cycle -> normal completion, o_rsp_timeout=0, slave data returned.
- i_csr_rst_n deasserted during CMD -> o_csr_cmd, o_busy and all o_rsp_valid go 0 without waiting for a clock edge. After release, the first grant goes to the lowest valid requester with no stale response.
